// File: rtl/grant_burst_mux_pkg.sv
// Shared definitions for grant_burst_mux and the arbiter benches:
// state encoding, requester count and one-hot to index helper.
package grant_burst_mux_pkg;

  localparam int NREQ = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  // Lowest set bit wins, so a multi-hot input still maps to a legal index.
  function automatic logic [1:0] oh2idx(
    input logic [NREQ-1:0] oh
  );
    logic [1:0] idx;
    idx = 2'd0;
    case (1'b1)
      oh[0]:   idx = 2'd0;
      oh[1]:   idx = 2'd1;
      oh[2]:   idx = 2'd2;
      oh[3]:   idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/grant_burst_mux_if.sv
// Grant, requester data and output beat port of grant_burst_mux.
// master drives grants/data/ready, slave is the mux itself.
interface grant_burst_mux_if
  import grant_burst_mux_pkg::*;
#(
  parameter int DW = 8
);

  logic [NREQ-1:0]    gnt;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_last;
  logic               out_ready;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic [1:0]         out_src;
  logic [NREQ-1:0]    pop;
  logic               busy;
  logic               gnt_err;

  modport master (
    output gnt,
    output req_data,
    output req_last,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_src,
    input  pop,
    input  busy,
    input  gnt_err
  );

  modport slave (
    input  gnt,
    input  req_data,
    input  req_last,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_src,
    output pop,
    output busy,
    output gnt_err
  );

endinterface

// File: rtl/grant_burst_mux_onehot4_enc.sv
// 4-bit one-hot to 2-bit index encoder with
// exactly-one and multi-hot flags.
module onehot4_enc
  import grant_burst_mux_pkg::*;
(
  input  logic [NREQ-1:0] oh,
  output logic [1:0]      idx,
  output logic            one,
  output logic            multi
);

  assign idx   = oh2idx(oh);
  assign multi = |(oh & (oh - 4'd1));
  assign one   = (|oh) & ~multi;

endmodule

// File: rtl/grant_burst_mux.sv
// Locks ownership to the granted requester for one burst and
// forwards its beats to a shared valid/ready output port.
module grant_burst_mux
  import grant_burst_mux_pkg::*;
#(
  parameter int DW        = 8,
  parameter int MAX_BEATS = 4,
  parameter int CW        = 2
) (
  input logic             clk,
  input logic             reset,
  grant_burst_mux_if.slave bus
);

  logic [1:0]    state;
  logic [1:0]    owner;
  logic [CW-1:0] beat_cnt;

  logic [1:0] gidx;
  logic       gone;
  logic       gmulti;

  onehot4_enc u_enc (
    .oh    (bus.gnt),
    .idx   (gidx),
    .one   (gone),
    .multi (gmulti)
  );

  logic in_xfer;
  logic acc;
  logic last_beat;

  assign in_xfer   = (state == XFER);
  assign acc       = in_xfer & bus.out_ready;
  assign last_beat = bus.req_last[owner] |
                     (beat_cnt == CW'(MAX_BEATS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= 2'd0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gone) begin
            owner    <= gidx;
            beat_cnt <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (acc) begin
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= GAP;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Reset gates gnt_err so every output reads 0 while reset is held.
  always_comb begin
    bus.out_valid = in_xfer;
    bus.out_data  = '0;
    bus.out_src   = owner;
    bus.pop       = '0;
    bus.busy      = (state != IDLE);
    bus.gnt_err   = reset & (state == IDLE) & gmulti;
    if (in_xfer) begin
      bus.out_data = bus.req_data[owner*DW +: DW];
    end
    if (acc) begin
      bus.pop[owner] = 1'b1;
    end
  end

endmodule
